turn_sequencer: RTL

- Game-flow controller for the Scrambled Number Sum game. It alternates two players and, per turn, requests a new puzzle from the scramble generator.
- Owns and sequences the two-digit BCD countdown timer: loads it from the time-setting switches, runs it, and ends the turn on a correct or incorrect submission or on time-out.
- Keeps per-player scores and the round count, and declares the winner after ROUNDS rounds.
- Sits between the input-pulse/debounce logic and the score/timer display drivers.

---
 rtl/turn_pkg.sv | 32 +++
 rtl/bcd_down_counter.sv | 50 +++++
 rtl/turn_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/turn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : turn_pkg
// Brief    : Shared types and constants for the turn sequencer game flow.
// Revision : 1.0 - initial release
// ============================================================================
package turn_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_PUZ = 3'd2,
        LOAD     = 3'd3,
        RUN      = 3'd4,
        JUDGE    = 3'd5,
        SWITCH   = 3'd6,
        DONE     = 3'd7
    } state_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P0   = 2'b01;
    localparam logic [1:0] W_P1   = 2'b10;
    localparam logic [1:0] W_TIE  = 2'b11;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_counter
// Brief    : Two-digit BCD down counter with clamped load and zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_down_counter
    import turn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_tens,
    input  logic [3:0] i_load_ones,
    input  logic       i_dec,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_zero
);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       w_zero;

    assign w_zero = (r_tens == 4'd0) && (r_ones == 4'd0);

    // Decrement stops at 00 rather than wrapping to 99.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (i_load) begin
            r_tens <= clamp_bcd(i_load_tens);
            r_ones <= clamp_bcd(i_load_ones);
        end else if (i_dec && !w_zero) begin
            if (r_ones == 4'd0) begin
                r_ones <= BCD_MAX;
                r_tens <= r_tens - 4'd1;
            end else begin
                r_ones <= r_ones - 4'd1;
            end
        end
    end

    assign o_tens = r_tens;
    assign o_ones = r_ones;
    assign o_zero = w_zero;

endmodule
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : turn_sequencer
// Brief    : Two-player game-flow controller: puzzle requests, turn timer,
//            judging, scores, rounds and winner.
// Revision : 1.0 - initial release
// ============================================================================
module turn_sequencer
    import turn_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int ROUNDS   = 5,
    parameter int SCORE_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         time_tens,
    input  logic [3:0]         time_ones,
    input  logic               puzzle_ready,
    input  logic [7:0]         expected,
    input  logic               submit,
    input  logic [7:0]         answer,
    output logic               new_puzzle_req,
    output logic               active_player,
    output logic [3:0]         timer_tens,
    output logic [3:0]         timer_ones,
    output logic               running,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [3:0]         round,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam int               c_PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [SCORE_W-1:0] c_SCORE_MAX = {SCORE_W{1'b1}};

    state_t               r_state;
    state_t               w_next_state;
    logic [c_PRE_W-1:0]   r_prescale;
    logic [7:0]           r_expected;
    logic [SCORE_W-1:0]   r_score0;
    logic [SCORE_W-1:0]   r_score1;
    logic [3:0]           r_round;
    logic                 r_active;
    logic                 r_running;

    logic                 w_tick;
    logic                 w_timeout;
    logic [3:0]           w_round_next;
    logic                 w_last_round;
    logic                 w_dec;
    logic [3:0]           w_tens;
    logic [3:0]           w_ones;
    logic                 w_zero;

    assign w_tick       = (r_state == RUN) && (r_prescale == c_PRE_W'(TICK_DIV - 1));
    // A tick times out when the counter is already at 00 or is about to reach it.
    assign w_timeout    = w_tick && (w_zero || ((w_tens == 4'd0) && (w_ones == 4'd1)));
    assign w_dec        = w_tick && !submit;
    assign w_round_next = r_active ? (r_round + 4'd1) : r_round;
    assign w_last_round = (w_round_next == 4'(ROUNDS));

    bcd_down_counter u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (r_state == LOAD),
        .i_load_tens (time_tens),
        .i_load_ones (time_ones),
        .i_dec       (w_dec),
        .o_tens      (w_tens),
        .o_ones      (w_ones),
        .o_zero      (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_running <= (w_next_state == RUN);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (start) w_next_state = REQ;
            REQ:      w_next_state = WAIT_PUZ;
            WAIT_PUZ: if (puzzle_ready) w_next_state = LOAD;
            LOAD:     w_next_state = RUN;
            RUN: begin
                if (submit)
                    w_next_state = JUDGE;
                else if (w_timeout)
                    w_next_state = SWITCH;
            end
            JUDGE:    w_next_state = SWITCH;
            SWITCH:   w_next_state = w_last_round ? DONE : REQ;
            DONE:     if (start) w_next_state = REQ;
            default:  w_next_state = IDLE;
        endcase
    end

    always_comb begin
        new_puzzle_req = (r_state == REQ);
        game_over      = (r_state == DONE);
        winner         = W_NONE;
        if (r_state == DONE) begin
            if (r_score0 > r_score1)
                winner = W_P0;
            else if (r_score1 > r_score0)
                winner = W_P1;
            else
                winner = W_TIE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= '0;
            r_expected <= 8'd0;
            r_score0   <= '0;
            r_score1   <= '0;
            r_round    <= 4'd0;
            r_active   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_score0 <= '0;
                        r_score1 <= '0;
                        r_round  <= 4'd0;
                        r_active <= 1'b0;
                    end
                end
                WAIT_PUZ: if (puzzle_ready) r_expected <= expected;
                LOAD:     r_prescale <= '0;
                RUN: begin
                    if (w_tick)
                        r_prescale <= '0;
                    else
                        r_prescale <= r_prescale + c_PRE_W'(1);
                end
                JUDGE: begin
                    if (answer == r_expected) begin
                        if (!r_active && (r_score0 != c_SCORE_MAX))
                            r_score0 <= r_score0 + SCORE_W'(1);
                        if (r_active && (r_score1 != c_SCORE_MAX))
                            r_score1 <= r_score1 + SCORE_W'(1);
                    end
                end
                SWITCH: begin
                    r_round <= w_round_next;
                    if (!w_last_round)
                        r_active <= ~r_active;
                end
                default: ;
            endcase
        end
    end

    assign active_player = r_active;
    assign timer_tens    = w_tens;
    assign timer_ones    = w_ones;
    assign running       = r_running;
    assign score0        = r_score0;
    assign score1        = r_score1;
    assign round         = r_round;

endmodule
`default_nettype wire
